// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } hz_state_t;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_controller_if
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int CNT_WIDTH = 16
);
    logic [REG_AW-1:0]    Rs1D, Rs2D, Rs1E, Rs2E;
    logic [REG_AW-1:0]    RdE, RdM, RdW;
    logic                 RegWriteM, RegWriteW;
    logic                 LoadE, PCSrcE, MemReqM, MemReadyM;
    fwd_sel_t             ForwardAE, ForwardBE;
    logic                 StallF, StallD, StallE, StallM;
    logic                 FlushD, FlushE, FlushW;
    logic                 MemError;
    logic [CNT_WIDTH-1:0] StallCount, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemError, StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemError, StallCount, FlushCount
    );
endinterface

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - forwarding select for one E-stage ALU operand
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output fwd_sel_t          fwd
);
    localparam logic [REG_AW-1:0] X0 = REG_AW'(ZERO_REG);

    // Younger producer (M) wins over older (W); x0 is never forwarded.
    always_comb begin
        fwd = FWD_NONE;
        if (reg_write_m && (rd_m != X0) && (rd_m == rs)) begin
            fwd = FWD_M;
        end else if (reg_write_w && (rd_w != X0) && (rd_w == rs)) begin
            fwd = FWD_W;
        end
    end
endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - forwarding, stall/flush and memory wait watchdog (optional HAZARD_PERF_EN perf counters)
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int MAX_WAIT  = 15,
    parameter int CNT_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    hazard_controller_if.slave hz
);
    localparam logic [REG_AW-1:0]    X0      = REG_AW'(ZERO_REG);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);

    fwd_sel_t             fwd_a, fwd_b;
    logic                 mem_stall, load_use;
    hz_state_t            state, state_nxt;
    logic [CNT_WIDTH-1:0] wait_cnt, wait_cnt_nxt;
    logic                 timeout;
    logic                 mem_error;
    logic                 stall_f, stall_d, stall_e, stall_m;
    logic                 flush_d, flush_e, flush_w;

    forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
        .rs(hz.Rs1E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .fwd(fwd_a)
    );

    forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
        .rs(hz.Rs2E), .rd_m(hz.RdM), .rd_w(hz.RdW),
        .reg_write_m(hz.RegWriteM), .reg_write_w(hz.RegWriteW), .fwd(fwd_b)
    );

    assign mem_stall = hz.MemReqM & ~hz.MemReadyM;
    assign load_use  = hz.LoadE & (hz.RdE != X0) & ((hz.RdE == hz.Rs1D) | (hz.RdE == hz.Rs2D));

    // State register: watchdog FSM, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (timeout) begin
                mem_error <= 1'b1;
            end
        end
    end

    // Next state: enter WAIT on an unacknowledged request, count until ready.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = CNT_WIDTH'(1);
                end
            end
            WAIT: begin
                if (hz.MemReadyM) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt != MAX_CNT) begin
                    wait_cnt_nxt = wait_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs: watchdog trip plus prioritised stall/flush; the freeze tracks mem_stall, not the state.
    always_comb begin
        timeout = (state == WAIT) && (wait_cnt == MAX_CNT) && !hz.MemReadyM;
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (hz.PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign hz.ForwardAE = rst ? FWD_NONE : fwd_a;
    assign hz.ForwardBE = rst ? FWD_NONE : fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.MemError  = mem_error;

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

    // Saturating perf counters for stalled and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stall_f | stall_d | stall_e | stall_m) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if ((flush_d | flush_e) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign hz.StallCount = stall_cnt;
    assign hz.FlushCount = flush_cnt;
`else
    assign hz.StallCount = '0;
    assign hz.FlushCount = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - vector and sequence checks for hazard_controller
module tb_hazard_controller;
    import hazard_pkg::*;

    typedef struct {
        logic       rst;
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, loade, pcsrc, memreq, memready;
        logic [1:0] fa, fb;
        logic [3:0] stall;
        logic [2:0] flush;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   exp_sc = 0;
    int   exp_fc = 0;

    always #5 clk = ~clk;

    hazard_controller_if #(.REG_AW(5), .CNT_WIDTH(16)) hz ();

    hazard_controller #(.REG_AW(5), .MAX_WAIT(15), .CNT_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .hz(hz)
    );

    function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                                input logic rwm, rww, loade, pcsrc, memreq, memready,
                                input logic [1:0] fa, fb, input logic [3:0] stall,
                                input logic [2:0] flush);
        vec_t v;
        v.rst = 1'b0;
        v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
        v.rde = rde; v.rdm = rdm; v.rdw = rdw;
        v.rwm = rwm; v.rww = rww; v.loade = loade; v.pcsrc = pcsrc;
        v.memreq = memreq; v.memready = memready;
        v.fa = fa; v.fb = fb; v.stall = stall; v.flush = flush;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check the combinational outputs, advance one clock.
    task automatic run_vec(input string name, input vec_t v);
        logic [12:0] act, exp;
        rst          = v.rst;
        hz.Rs1D      = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e; hz.Rs2E = v.rs2e;
        hz.RdE       = v.rde;  hz.RdM  = v.rdm;  hz.RdW  = v.rdw;
        hz.RegWriteM = v.rwm;  hz.RegWriteW = v.rww;
        hz.LoadE     = v.loade; hz.PCSrcE = v.pcsrc;
        hz.MemReqM   = v.memreq; hz.MemReadyM = v.memready;
        #1;
        act = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE, hz.StallM,
               hz.FlushD, hz.FlushE, hz.FlushW};
        exp = {v.fa, v.fb, v.stall, v.flush};
        chk(name, 32'(act), 32'(exp));
        @(posedge clk);
        if (v.rst) begin
            exp_sc = 0;
            exp_fc = 0;
        end else begin
            if (v.stall != 4'b0000) exp_sc++;
            if (v.flush[2:1] != 2'b00) exp_fc++;
        end
        #1;
    endtask

    task automatic chk_perf(input string name);
`ifdef HAZARD_PERF_EN
        chk({name, "_stallcnt"}, 32'(hz.StallCount), 32'(exp_sc));
        chk({name, "_flushcnt"}, 32'(hz.FlushCount), 32'(exp_fc));
`else
        chk({name, "_stallcnt"}, 32'(hz.StallCount), 32'd0);
        chk({name, "_flushcnt"}, 32'(hz.FlushCount), 32'd0);
`endif
    endtask

    vec_t tbl[13];
    vec_t v;

    initial begin
        //              rs1d rs2d rs1e rs2e rde rdm rdw rwm rww ld pc mq mr  fa     fb     stall    flush(D,E,W)
        tbl[0]  = mk(0, 0, 5, 0, 0, 5, 5, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00, 4'b0000, 3'b000);
        tbl[1]  = mk(0, 0, 5, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 4'b0000, 3'b000);
        tbl[2]  = mk(0, 0, 5, 7, 0, 7, 5, 1, 1, 0, 0, 0, 0, 2'b01, 2'b10, 4'b0000, 3'b000);
        tbl[3]  = mk(0, 0, 5, 5, 0, 5, 5, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[5]  = mk(0, 6, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010);
        tbl[6]  = mk(6, 0, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[8]  = mk(6, 0, 0, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[9]  = mk(0, 6, 0, 0, 6, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b110);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b000);
        tbl[12] = mk(0, 6, 5, 0, 6, 5, 0, 1, 0, 1, 1, 1, 0, 2'b10, 2'b00, 4'b1111, 3'b001);

        // Reset with hazard-provoking inputs: stalls off, all flushes on, forwarding off.
        v = tbl[12];
        v.rst = 1'b1; v.fa = 2'b00; v.stall = 4'b0000; v.flush = 3'b111;
        run_vec("reset_outputs", v);
        chk("reset_memerror", 32'(hz.MemError), 32'd0);
        chk("reset_state", 32'(dut.state), 32'(RUN));
        chk_perf("reset");

        for (int i = 0; i < 13; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Load-use: one bubble, then the load sits in W and is forwarded.
        v = tbl[0]; v.rst = 1'b1; v.fa = 2'b00; v.flush = 3'b111;
        run_vec("reset2", v);
        run_vec("lu_c1", mk(0, 6, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'b010));
        run_vec("lu_c2", mk(0, 6, 0, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000));
        run_vec("lu_c3", mk(0, 0, 0, 6, 0, 0, 6, 0, 1, 0, 0, 0, 0, 2'b00, 2'b01, 4'b0000, 3'b000));

        // Three-cycle memory wait, then release.
        for (int i = 1; i <= 3; i++) begin
            run_vec($sformatf("mw_c%0d", i),
                    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b1111, 3'b001));
            chk($sformatf("mw_state%0d", i), 32'(dut.state), 32'(WAIT));
            chk($sformatf("mw_cnt%0d", i), 32'(dut.wait_cnt), 32'(i));
        end
        run_vec("mw_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b000));
        chk("mw_back_run", 32'(dut.state), 32'(RUN));
        chk("mw_cnt_clear", 32'(dut.wait_cnt), 32'd0);
        chk_perf("after_mw");

        // Watchdog: error appears after the counter has sat at MAX_WAIT in WAIT.
        for (int i = 1; i <= 16; i++) begin
            run_vec($sformatf("to_c%0d", i),
                    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b1111, 3'b001));
            if (i == 15) chk("to_not_yet", 32'(hz.MemError), 32'd0);
        end
        chk("to_set", 32'(hz.MemError), 32'd1);
        chk("to_cnt_sat", 32'(dut.wait_cnt), 32'd15);
        run_vec("to_ready", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 4'b0000, 3'b000));
        run_vec("to_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000));
        chk("to_sticky", 32'(hz.MemError), 32'd1);
        chk_perf("after_to");
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 3'b111);
        v.rst = 1'b1;
        run_vec("to_reset", v);
        chk("to_cleared", 32'(hz.MemError), 32'd0);

        // Reset arriving while in WAIT.
        for (int i = 1; i <= 2; i++) begin
            run_vec($sformatf("rw_c%0d", i),
                    mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 4'b1111, 3'b001));
        end
        chk("rw_in_wait", 32'(dut.state), 32'(WAIT));
        run_vec("rw_reset", v);
        chk("rw_state", 32'(dut.state), 32'(RUN));
        chk("rw_cnt", 32'(dut.wait_cnt), 32'd0);
        run_vec("final_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 3'b000));
        chk_perf("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
